// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host and memory-side signals shared by the data memory arbiter and its environment
interface dmem_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [NUM_CORES-1:0] core_req;
  logic [NUM_CORES-1:0] core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0] core_gnt;
  logic [NUM_CORES-1:0] core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic host_req;
  logic host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic host_gnt;
  logic host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input core_req, core_we, core_addr, core_wdata, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output core_gnt, core_rvalid, core_rdata, host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input core_gnt, core_rvalid, core_rdata, host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: host-priority, round-robin burst-limited arbiter for a single-port data memory
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rstn,
  dmem_arbiter_if.slave bus
);
  localparam int ow = $clog2(NUM_CORES);
  logic [ow-1:0] owner, pick, g;
  logic [3:0] burst_cnt;
  logic [NUM_CORES-1:0] others, rd_core;
  logic found, cont, core_go, rd_host;
  always_comb begin
    found = 1'b0;
    pick = owner;
    for (int k = 1; k <= NUM_CORES; k++)
      if (!found && bus.core_req[(int'(owner) + k) % NUM_CORES]) begin
        found = 1'b1;
        pick = ow'((int'(owner) + k) % NUM_CORES);
      end
  end
  assign others = bus.core_req & ~(NUM_CORES'(1) << owner);
  assign cont = bus.core_req[owner] && burst_cnt != 4'd0 && (burst_cnt < 4'(MAX_BURST) || others == '0);
  assign core_go = !bus.host_req && (cont || found);
  assign g = cont ? owner : pick;
  assign bus.host_gnt = bus.host_req;
  assign bus.core_gnt = core_go ? NUM_CORES'(1) << g : '0;
  assign bus.mem_en = bus.host_req || core_go;
  assign bus.mem_we = bus.host_req ? bus.host_we : core_go && bus.core_we[g];
  assign bus.mem_addr = bus.host_req ? bus.host_addr : core_go ? bus.core_addr[int'(g)*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_wdata = bus.host_req ? bus.host_wdata : core_go ? bus.core_wdata[int'(g)*DATA_W +: DATA_W] : '0;
  assign bus.core_rvalid = rd_core;
  assign bus.host_rvalid = rd_host;
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      owner <= ow'(NUM_CORES - 1);
      burst_cnt <= '0;
      rd_core <= '0;
      rd_host <= 1'b0;
    end else begin
      if (core_go) begin
        owner <= g;
        burst_cnt <= !cont ? 4'd1 : burst_cnt == 4'd15 ? burst_cnt : burst_cnt + 4'd1;
      end
      rd_core <= core_go && !bus.core_we[g] ? NUM_CORES'(1) << g : '0;
      rd_host <= bus.host_req && !bus.host_we;
    end
endmodule
